// File: rtl/mdu_pkg.sv
//------------------------------------------------------------------------------
// Module  : mdu_pkg
// Brief   : Shared FSM state encoding and M-extension funct3 codes for mdu_seq.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

endpackage

`default_nettype wire

// File: rtl/mdu_step.sv
//------------------------------------------------------------------------------
// Module  : mdu_step
// Brief   : One unsigned iteration: shift-add multiply or restoring divide.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_step
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_top;
    logic [XLEN:0] w_diff;

    // Divide keeps {remainder, quotient}; multiply keeps {partial, multiplier}.
    always_comb begin
        w_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
        w_top  = acc_i[2*XLEN-1:XLEN-1];
        w_diff = w_top - {1'b0, opnd_i};
        acc_o  = '0;
        if (is_div_i) begin
            if (!w_diff[XLEN]) begin
                acc_o = {w_diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {w_top[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {w_sum, acc_i[XLEN-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*XLEN-1:1]};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
//------------------------------------------------------------------------------
// Module  : mdu_seq
// Brief   : Sequential RV32M multiply/divide unit, one iteration per cycle.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int c_CNT_W = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);

    mdu_state_e          r_state;
    mdu_state_e          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_neg_prod;
    logic [XLEN-1:0]     r_opnd;
    logic [XLEN-1:0]     r_result;
    logic [XLEN-1:0]     w_final;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [2:0]          r_funct3;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                w_sgn_a;
    logic                w_sgn_b;
    logic                w_div0;
    logic                w_ovf;
    logic                w_accept;

    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (funct3_i)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                w_sgn_a = op_a_i[XLEN-1];
                w_sgn_b = op_b_i[XLEN-1];
            end
            MDU_MULHSU: w_sgn_a = op_a_i[XLEN-1];
            default:    ;
        endcase
        w_mag_a = w_sgn_a ? -op_a_i : op_a_i;
        w_mag_b = w_sgn_b ? -op_b_i : op_b_i;
        w_div0  = funct3_i[2] && (op_b_i == '0);
        w_ovf   = ((funct3_i == MDU_DIV) || (funct3_i == MDU_REM)) &&
                  (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && !flush_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_div0 || w_ovf) ? DONE : CALC;
                end
            end
            CALC:    if (r_cnt == c_LAST) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
        ready_o = (r_state == IDLE);
        stall_o = w_accept || (r_state == CALC);
        done_o  = (r_state == DONE) && !flush_i;
    end

    mdu_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (r_funct3[2]),
        .acc_i    (r_acc),
        .opnd_i   (r_opnd),
        .acc_o    (w_acc_step)
    );

    // Special divide cases preload the accumulator with the final answer and
    // clear the sign flags, so DONE needs no separate bypass path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_funct3 <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_funct3 <= funct3_i;
                r_cnt    <= '0;
                r_opnd   <= w_mag_b;
                r_neg_q  <= w_sgn_a ^ w_sgn_b;
                r_neg_r  <= w_sgn_a;
                if (w_div0) begin
                    r_acc   <= {op_a_i, {XLEN{1'b1}}};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else if (w_ovf) begin
                    r_acc   <= {{XLEN{1'b0}}, op_a_i};
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                end else begin
                    r_acc <= {{XLEN{1'b0}}, w_mag_a};
                end
            end else if (r_state == CALC) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if (done_o) begin
                r_result <= w_final;
            end
        end
    end

    always_comb begin
        w_neg_prod = -r_acc;
        case (r_funct3)
            MDU_MUL:                         w_final = r_acc[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_final = r_neg_q ? w_neg_prod[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:               w_final = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            default:                         w_final = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        endcase
        result_o = done_o ? w_final : r_result;
    end

endmodule

`default_nettype wire

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL expose clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL expose rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL expose start_i, input, 1 bit, M-extension request valid from EX stage (funct7 = 0000001, ALUop = 10).
REQ-005 The block SHALL expose funct3_i, input, 3 bits, selecting MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU (000..111).
REQ-006 The block SHALL expose op_a_i and op_b_i, inputs, XLEN bits each, rs1 and rs2 operands.
REQ-007 The block SHALL expose flush_i, input, 1 bit, pipeline kill of the in-flight operation.
REQ-008 The block SHALL expose ready_o, output, 1 bit, high only in IDLE.
REQ-009 The block SHALL expose stall_o, output, 1 bit, pipeline freeze request.
REQ-010 The block SHALL expose done_o, output, 1 bit, one-cycle result-valid pulse.
REQ-011 The block SHALL expose result_o, output, XLEN bits, final product half, quotient or remainder.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, DONE.
REQ-013 A request SHALL be accepted only when start_i=1 and state=IDLE; start_i in CALC/DONE SHALL be ignored.
REQ-014 On accept the block SHALL register funct3, operand magnitudes (signed ops: DIV/REM/MULH both signed, MULHSU op_a only) and result sign flags, clear a 5-bit counter, and enter CALC.
REQ-015 CALC SHALL perform one shift-add (multiply) or restoring subtract-shift (divide) step per cycle into a 2*XLEN accumulator, XLEN steps total, then enter DONE after counter=XLEN-1.
REQ-016 DONE SHALL apply two's-complement sign correction, select low product (MUL), high product (MULH*), quotient or remainder, assert done_o for exactly one cycle, then return to IDLE.
REQ-017 Normal latency SHALL be XLEN+1 cycles: accept edge T, done_o high in cycle T+XLEN+1.
REQ-018 Divide by zero SHALL bypass CALC (DONE at T+1): DIV/DIVU quotient all ones, REM/REMU result = op_a.
REQ-019 Signed overflow (DIV/REM, op_a = most negative, op_b = -1) SHALL bypass CALC: quotient = op_a, remainder = 0.
REQ-020 Remainder sign SHALL follow dividend; quotient sign SHALL be XOR of operand signs.
REQ-021 stall_o SHALL equal (start_i AND IDLE AND NOT flush_i) OR CALC; it SHALL be low in DONE so EX advances with result.
REQ-022 result_o SHALL hold its last value until the next done_o.
REQ-023 flush_i SHALL force IDLE next edge from any state, suppress done_o, and win over a simultaneous start_i or completion.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, counter 0, accumulator 0, result_o 0, done_o 0, ready_o 1 after the edge, stall_o 0, including mid-CALC.

Structure
REQ-025 Package mdu_pkg SHALL hold the state enum and funct3 constants (MDU_MUL..MDU_REMU).
REQ-026 Sub-module mdu_step SHALL implement one combinational multiply/divide iteration; FSM, counter and sign handling stay in mdu_seq.

Verification
REQ-027 MUL 7 x -3 -> done_o at T+33, result 0xFFFFFFEB; stall_o high T..T+32, low at T+33.
REQ-028 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-029 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/0 -> 0xFFFFFFFF at T+1; REMU 100/0 -> 100.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM same -> 0.
REQ-031 flush_i at T+10 of a DIV -> IDLE at T+11, no done_o; new start at T+12 completes normally.
REQ-032 rst_n low at T+5 of MUL -> all outputs reset values next cycle; start_i during CALC ignored (single done_o).
